// File: rtl/mux_scan_n.sv
// mux_scan_n: N:1 channel mux with manual select or dwell-timed round-robin scan, registered ready/valid output.
// Optional channel masking (skip disabled channels in scan, reject masked sel) is enabled by defining MUX_CHAN_MASK_EN.
module mux_scan_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SELW     = 2,
  parameter int DWELLW   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [DWELLW-1:0]         dwell,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SELW-1:0]           y_chan,
  output logic                      sel_err
`ifdef MUX_CHAN_MASK_EN
  ,
  input  logic [CHANNELS-1:0]       chan_mask
`endif
);
  logic [SELW-1:0]       ptr;
  logic [SELW-1:0]       nxt;
  logic [SELW-1:0]       src;
  logic [DWELLW-1:0]     dcnt;
  logic                  mode_q;
  logic                  free;
  logic                  sel_ok;
  logic                  ptr_en;
  logic [WIDTH-1:0]      data;
`ifdef MUX_CHAN_MASK_EN
  logic [(1<<SELW)-1:0]  en_p;
  always_comb begin
    en_p = '0;
    en_p[CHANNELS-1:0] = chan_mask;
  end
  // descending search so the nearest enabled channel after ptr wins; none enabled -> ptr holds
  always_comb begin
    nxt = ptr;
    for (int i = CHANNELS; i >= 1; i--)
      if (chan_mask[(int'(ptr) + i) % CHANNELS]) nxt = SELW'((int'(ptr) + i) % CHANNELS);
  end
  assign sel_ok = (int'(sel) < CHANNELS) && en_p[sel];
  assign ptr_en = en_p[ptr];
`else
  assign nxt    = (ptr == SELW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
  assign sel_ok = int'(sel) < CHANNELS;
  assign ptr_en = 1'b1;
`endif
  assign free = !y_valid || out_ready;
  assign src  = mode ? ptr : sel;
  assign data = in_bus[int'(src)*WIDTH +: WIDTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_chan  <= '0;
      sel_err <= 1'b0;
      ptr     <= '0;
      dcnt    <= '0;
      mode_q  <= 1'b0;
    end else begin
      mode_q  <= mode;
      sel_err <= 1'b0;
      if (free) y_valid <= 1'b0;
      if (!mode) begin
        if (!sel_ok) sel_err <= 1'b1;
        else if (free) begin
          y       <= data;
          y_chan  <= sel;
          y_valid <= 1'b1;
        end
      end else if (!mode_q) begin
        ptr  <= '0;
        dcnt <= '0;
      end else if (dcnt != '0) dcnt <= dcnt - 1'b1;
      else if (!ptr_en) ptr <= nxt;
      else if (free) begin
        y       <= data;
        y_chan  <= ptr;
        y_valid <= 1'b1;
        ptr     <= nxt;
        dcnt    <= dwell;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed table-driven checks of mux_scan_n plus hand sequences for dwell/stall, reset and 3-channel sel_err.
module tb_mux_scan_n;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [31:0] in_bus = 32'h44332211;
  logic [3:0]  dwell = '0;
  logic        out_ready = 1'b1;
  logic [7:0]  y;
  logic        y_valid;
  logic [1:0]  y_chan;
  logic        sel_err;
  logic [1:0]  sel3 = '0;
  logic [7:0]  y3;
  logic        y_valid3;
  logic [1:0]  y_chan3;
  logic        sel_err3;
  int checks = 0;
  int errors = 0;
`ifdef MUX_CHAN_MASK_EN
  logic [3:0]  chan_mask = 4'b1111;
  logic [2:0]  chan_mask3 = 3'b111;
`endif

  always #5 clk = ~clk;

  mux_scan_n dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_bus(in_bus), .dwell(dwell),
    .out_ready(out_ready), .y(y), .y_valid(y_valid), .y_chan(y_chan), .sel_err(sel_err)
`ifdef MUX_CHAN_MASK_EN
    , .chan_mask(chan_mask)
`endif
  );

  mux_scan_n #(.CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(1'b0), .sel(sel3), .in_bus(in_bus[23:0]), .dwell(4'd0),
    .out_ready(1'b1), .y(y3), .y_valid(y_valid3), .y_chan(y_chan3), .sel_err(sel_err3)
`ifdef MUX_CHAN_MASK_EN
    , .chan_mask(chan_mask3)
`endif
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] dwell;
    logic       rdy;
    logic [7:0] ey;
    logic       ev;
    logic [1:0] ec;
    logic       ee;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [7:0] ey, input logic ev, input logic [1:0] ec);
    chk({name, ".y"}, 32'(y), 32'(ey));
    chk({name, ".y_valid"}, 32'(y_valid), 32'(ev));
    chk({name, ".y_chan"}, 32'(y_chan), 32'(ec));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 4'd0, 1'b1, 8'h33, 1'b1, 2'd2, 1'b0};
    vecs[1]  = '{1'b0, 2'd3, 4'd0, 1'b1, 8'h44, 1'b1, 2'd3, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 4'd0, 1'b0, 8'h44, 1'b1, 2'd3, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 4'd0, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h11, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h22, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h33, 1'b1, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h44, 1'b1, 2'd3, 1'b0};
    vecs[9]  = '{1'b1, 2'd0, 4'd0, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 4'd0, 1'b1, 8'h22, 1'b1, 2'd1, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 1'b0, 2'd0);
    chk("reset.sel_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mode = vecs[i].mode;
      sel = vecs[i].sel;
      dwell = vecs[i].dwell;
      out_ready = vecs[i].rdy;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].ey, vecs[i].ev, vecs[i].ec);
      chk($sformatf("vec%0d.sel_err", i), 32'(sel_err), 32'(vecs[i].ee));
    end
    // dwell=3: entry cycle, then a load every 4 clks
    mode = 1'b1;
    dwell = 4'd3;
    out_ready = 1'b1;
    step();
    chk("dwell.entry_valid", 32'(y_valid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("dwell.valid%0d", k), 32'(y_valid), (k == 1 || k == 5) ? 32'd1 : 32'd0);
    end
    chk_out("dwell.second", 8'h22, 1'b1, 2'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_out($sformatf("stall%0d", k), 8'h22, 1'b1, 2'd1);
    end
    out_ready = 1'b1;
    step();
    chk_out("stall.release", 8'h33, 1'b1, 2'd2);
    // asynchronous reset mid-scan while y_valid=1
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 1'b0, 2'd0);
    dwell = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst.entry_valid", 32'(y_valid), 32'd0);
    step();
    chk_out("rst.first", 8'h11, 1'b1, 2'd0);
    // scan never raises sel_err even with an out-of-range sel
    sel = 2'd3;
    step();
    chk("scan.sel_err", 32'(sel_err), 32'd0);
    // 3-channel build: sel=3 is invalid
    sel3 = 2'd2;
    step();
    chk("c3.load_y", 32'(y3), 32'h33);
    chk("c3.load_err", 32'(sel_err3), 32'd0);
    sel3 = 2'd3;
    step();
    chk("c3.err", 32'(sel_err3), 32'd1);
    chk("c3.err_y", 32'(y3), 32'h33);
    chk("c3.err_valid", 32'(y_valid3), 32'd0);
    sel3 = 2'd1;
    step();
    chk("c3.err_pulse", 32'(sel_err3), 32'd0);
    chk("c3.recover_y", 32'(y3), 32'h22);
`ifdef MUX_CHAN_MASK_EN
    mode = 1'b0;
    sel = 2'd0;
    step();
    chan_mask = 4'b1010;
    mode = 1'b1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mask.chan%0d", k), 32'(y_chan), (k % 2 == 0) ? 32'd1 : 32'd3);
      chk($sformatf("mask.valid%0d", k), 32'(y_valid), 32'd1);
    end
    chan_mask = 4'b0000;
    step();
    chk("mask0.valid_a", 32'(y_valid), 32'd0);
    step();
    chk("mask0.valid_b", 32'(y_valid), 32'd0);
    chan_mask = 4'b0010;
    step();
    chk_out("mask.resume", 8'h22, 1'b1, 2'd1);
    mode = 1'b0;
    sel = 2'd0;
    step();
    chk("mask.manual_err", 32'(sel_err), 32'd1);
    chk("mask.manual_chan", 32'(y_chan), 32'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
